// File: rtl/shift_sched_if.sv
// shift_sched_if: requester-side handshake bundle for shift_sched (al_*/nm_* request, grant, done, res_o, busy_o)
interface shift_sched_if #(
  parameter int SWR = 55,
  parameter int EWR = 6
);
  logic           al_req_i;
  logic [EWR-1:0] al_shift_i;
  logic [SWR-1:0] al_data_i;
  logic           al_bit_i;
  logic           al_gnt_o;
  logic           al_done_o;
  logic           nm_req_i;
  logic [EWR-1:0] nm_shift_i;
  logic [SWR-1:0] nm_data_i;
  logic           nm_bit_i;
  logic           nm_gnt_o;
  logic           nm_done_o;
  logic [SWR-1:0] res_o;
  logic           busy_o;
  modport master (
    output al_req_i, al_shift_i, al_data_i, al_bit_i,
    output nm_req_i, nm_shift_i, nm_data_i, nm_bit_i,
    input  al_gnt_o, al_done_o, nm_gnt_o, nm_done_o, res_o, busy_o
  );
  modport slave (
    input  al_req_i, al_shift_i, al_data_i, al_bit_i,
    input  nm_req_i, nm_shift_i, nm_data_i, nm_bit_i,
    output al_gnt_o, al_done_o, nm_gnt_o, nm_done_o, res_o, busy_o
  );
endinterface

// File: rtl/shift_sched.sv
// shift_sched: arbitrates alignment (right) / normalization (left) requests onto one barrel shifter; ports clk, rst, req (shift_sched_if.slave), sh_* shifter drive, sh_result_i; define SHIFT_SCHED_RR_ARB_EN for round-robin arbitration
module shift_sched #(
  parameter int SWR = 55,
  parameter int EWR = 6,
  parameter int SHIFT_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  shift_sched_if.slave   req,
  output logic           sh_load_o,
  output logic [EWR-1:0] sh_value_o,
  output logic [SWR-1:0] sh_data_o,
  output logic           sh_left_right_o,
  output logic           sh_bit_o,
  input  logic [SWR-1:0] sh_result_i
);
  typedef enum logic [1:0] {IDLE, SHIFT, CAPT} state_t;
  state_t         state, state_n;
  logic [3:0]     cnt;
  logic           owner;
  logic [EWR-1:0] op_value;
  logic [SWR-1:0] op_data;
  logic           op_bit;
  logic [SWR-1:0] res;
  logic           done_al, done_nm;
  logic           any_req, win_nm, start;
  assign any_req = req.al_req_i | req.nm_req_i;
  assign start = (state == IDLE) & any_req;
`ifdef SHIFT_SCHED_RR_ARB_EN
  logic ptr;
  assign win_nm = req.nm_req_i & (~req.al_req_i | ptr);
  always_ff @(posedge clk)
    if (rst) ptr <= 1'b0;
    else if (start) ptr <= ~win_nm;
`else
  assign win_nm = req.nm_req_i & ~req.al_req_i;
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = any_req ? SHIFT : IDLE;
      SHIFT:   state_n = (cnt == 4'(SHIFT_LAT - 1)) ? CAPT : SHIFT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      owner    <= 1'b0;
      op_value <= '0;
      op_data  <= '0;
      op_bit   <= 1'b0;
      res      <= '0;
      done_al  <= 1'b0;
      done_nm  <= 1'b0;
    end else begin
      cnt     <= (state == SHIFT) ? cnt + 4'd1 : '0;
      done_al <= (state == CAPT) & ~owner;
      done_nm <= (state == CAPT) & owner;
      if (start) begin
        owner    <= win_nm;
        op_value <= win_nm ? req.nm_shift_i : req.al_shift_i;
        op_data  <= win_nm ? req.nm_data_i : req.al_data_i;
        op_bit   <= win_nm ? req.nm_bit_i : req.al_bit_i;
      end
      if (state == CAPT) res <= sh_result_i;
    end
  end
  assign sh_load_o       = state == SHIFT;
  assign sh_value_o      = op_value;
  assign sh_data_o       = op_data;
  assign sh_left_right_o = owner;
  assign sh_bit_o        = op_bit;
  assign req.al_gnt_o    = (state == SHIFT) & (cnt == 4'd0) & ~owner;
  assign req.nm_gnt_o    = (state == SHIFT) & (cnt == 4'd0) & owner;
  assign req.al_done_o   = done_al;
  assign req.nm_done_o   = done_nm;
  assign req.res_o       = res;
  assign req.busy_o      = state != IDLE;
endmodule

// File: tb/tb_shift_sched.sv
// tb_shift_sched: directed self-checking bench for shift_sched with a behavioural barrel shifter model
module tb_shift_sched;
  localparam int SWR = 55;
  localparam int EWR = 6;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic           sh_load;
  logic [EWR-1:0] sh_value;
  logic [SWR-1:0] sh_data;
  logic           sh_lr;
  logic           sh_bit;
  logic [SWR-1:0] sh_result;
  int total = 0;
  int bad = 0;
  shift_sched_if #(.SWR(SWR), .EWR(EWR)) bus ();
  shift_sched #(.SWR(SWR), .EWR(EWR), .SHIFT_LAT(2)) dut (
    .clk(clk), .rst(rst), .req(bus),
    .sh_load_o(sh_load), .sh_value_o(sh_value), .sh_data_o(sh_data),
    .sh_left_right_o(sh_lr), .sh_bit_o(sh_bit), .sh_result_i(sh_result)
  );
  always #5 clk = ~clk;
  function automatic logic [SWR-1:0] shf(input logic [SWR-1:0] d, input logic [EWR-1:0] v,
                                         input logic l, input logic b);
    logic [SWR-1:0] r;
    r = d;
    for (int i = 0; i < int'(v); i++) r = l ? {r[SWR-2:0], b} : {b, r[SWR-1:1]};
    return r;
  endfunction
  always_comb sh_result = shf(sh_data, sh_value, sh_lr, sh_bit);
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [SWR-1:0] got, input logic [SWR-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic clear_inputs;
    bus.al_req_i = 0; bus.al_shift_i = '0; bus.al_data_i = '0; bus.al_bit_i = 0;
    bus.nm_req_i = 0; bus.nm_shift_i = '0; bus.nm_data_i = '0; bus.nm_bit_i = 0;
  endtask
  task automatic do_reset;
    clear_inputs();
    rst = 1; tick(); tick(); rst = 0;
  endtask
  task automatic test_reset;
    do_reset();
    tick();
    chk("rst_al_gnt", SWR'(bus.al_gnt_o), '0);
    chk("rst_nm_gnt", SWR'(bus.nm_gnt_o), '0);
    chk("rst_al_done", SWR'(bus.al_done_o), '0);
    chk("rst_nm_done", SWR'(bus.nm_done_o), '0);
    chk("rst_res", bus.res_o, '0);
    chk("rst_busy", SWR'(bus.busy_o), '0);
    chk("rst_load", SWR'(sh_load), '0);
    chk("rst_value", SWR'(sh_value), '0);
    chk("rst_data", sh_data, '0);
    chk("rst_lr_bit", SWR'({sh_lr, sh_bit}), '0);
  endtask
  task automatic test_single_right;
    logic [SWR-1:0] d;
    d = 55'h40_0000_0000_0000;
    bus.al_req_i = 1; bus.al_shift_i = 6'd3; bus.al_data_i = d; bus.al_bit_i = 0;
    tick();
    chk("r_c1_gnt", SWR'({bus.al_gnt_o, bus.nm_gnt_o}), 55'b10);
    chk("r_c1_load", SWR'(sh_load), 55'd1);
    chk("r_c1_lr", SWR'(sh_lr), '0);
    chk("r_c1_value", SWR'(sh_value), 55'd3);
    bus.al_req_i = 0;
    tick();
    chk("r_c2_load_gnt", SWR'({sh_load, bus.al_gnt_o}), 55'b10);
    tick();
    chk("r_c3_load_busy_done", SWR'({sh_load, bus.busy_o, bus.al_done_o}), 55'b010);
    tick();
    chk("r_c4_done", SWR'({bus.al_done_o, bus.nm_done_o, bus.busy_o}), 55'b100);
    chk("r_c4_res", bus.res_o, 55'h08_0000_0000_0000);
    tick();
    chk("r_c5_done", SWR'(bus.al_done_o), '0);
    chk("r_c5_res_held", bus.res_o, 55'h08_0000_0000_0000);
  endtask
  task automatic test_single_left;
    bus.nm_req_i = 1; bus.nm_shift_i = 6'd5; bus.nm_data_i = 55'd1; bus.nm_bit_i = 0;
    tick();
    chk("l_c1_gnt", SWR'({bus.al_gnt_o, bus.nm_gnt_o}), 55'b01);
    chk("l_c1_lr", SWR'(sh_lr), 55'd1);
    bus.nm_req_i = 0;
    tick();
    chk("l_c2_lr_load", SWR'({sh_lr, sh_load}), 55'b11);
    tick();
    chk("l_c3_done", SWR'(bus.nm_done_o), '0);
    tick();
    chk("l_c4_done", SWR'({bus.al_done_o, bus.nm_done_o}), 55'b01);
    chk("l_c4_res", bus.res_o, 55'h20);
  endtask
  task automatic test_back_to_back;
    bus.al_req_i = 1; bus.al_shift_i = 6'd4; bus.al_data_i = 55'h100; bus.al_bit_i = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("b2b_c%0d_gnt", c), SWR'(bus.al_gnt_o), SWR'(c == 1 || c == 5));
      chk($sformatf("b2b_c%0d_done", c), SWR'(bus.al_done_o), SWR'(c == 4 || c == 8));
      if (c == 4) chk("b2b_res1", bus.res_o, 55'h10);
      if (c == 8) chk("b2b_res2", bus.res_o, 55'h100);
      if (c == 2) begin bus.al_data_i = 55'h200; bus.al_shift_i = 6'd1; end
      if (c == 6) begin bus.al_data_i = 55'hFFFF; bus.al_shift_i = 6'd0; end
      if (c == 7) bus.al_req_i = 0;
    end
    tick();
    chk("b2b_idle_after", SWR'({bus.al_done_o, bus.busy_o}), '0);
  endtask
  task automatic test_simultaneous;
    logic [2:0] exp_nm;
    int k;
`ifdef SHIFT_SCHED_RR_ARB_EN
    exp_nm = 3'b010;
`else
    exp_nm = 3'b000;
`endif
    do_reset();
    bus.al_req_i = 1; bus.al_shift_i = 6'd1; bus.al_data_i = 55'd8;
    bus.nm_req_i = 1; bus.nm_shift_i = 6'd1; bus.nm_data_i = 55'd8;
    for (int c = 1; c <= 12; c++) begin
      tick();
      k = (c - 1) / 4;
      if (c % 4 == 1)
        chk($sformatf("sim_gnt%0d", k), SWR'({bus.al_gnt_o, bus.nm_gnt_o}),
            exp_nm[k] ? 55'b01 : 55'b10);
      if (c % 4 == 0) begin
        chk($sformatf("sim_done%0d", k), SWR'({bus.al_done_o, bus.nm_done_o}),
            exp_nm[k] ? 55'b01 : 55'b10);
        chk($sformatf("sim_res%0d", k), bus.res_o, exp_nm[k] ? 55'd16 : 55'd4);
      end
      if (c == 9) begin bus.al_req_i = 0; bus.nm_req_i = 0; end
    end
  endtask
  task automatic test_reset_mid_op;
    int seen;
    int n;
    clear_inputs();
    tick();
    bus.nm_req_i = 1; bus.nm_shift_i = 6'd1; bus.nm_data_i = 55'd1;
    tick();
    chk("abort_gnt", SWR'(bus.nm_gnt_o), 55'd1);
    bus.nm_req_i = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("abort_load_busy", SWR'({sh_load, bus.busy_o}), '0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.nm_done_o || bus.al_done_o) seen++;
      tick();
    end
    chk("abort_no_done", SWR'(seen), '0);
    bus.nm_req_i = 1; bus.nm_shift_i = 6'd2; bus.nm_data_i = 55'd3; bus.nm_bit_i = 1;
    tick();
    bus.nm_req_i = 0;
    n = 1;
    while (!bus.nm_done_o && n < 10) begin tick(); n++; end
    chk("after_abort_latency", SWR'(n), 55'd4);
    chk("after_abort_res", bus.res_o, 55'hF);
  endtask
  initial begin
    clear_inputs();
    test_reset();
    test_single_right();
    test_single_left();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
